mb_config_loader: RTL

MB_CONFIG_LOADER -- requirements
Module: mb_config_loader

---
 rtl/mb_config_pkg.sv | 28 ++
 rtl/mb_wl_decoder.sv | 46 ++++
 rtl/mb_config_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mb_config_pkg.sv
// ---------------------------------------------------------------------------
// mb_config_pkg
// Shared definitions for the fabric configuration loader: loader state
// encoding, default fabric geometry and the data-words-per-frame derivation.
// ---------------------------------------------------------------------------
package mb_config_pkg;

    localparam int DEF_BL_WIDTH = 514;  // fabric bit lines
    localparam int DEF_WL_WIDTH = 407;  // fabric word lines
    localparam int DEF_WORD_W   = 32;   // bitstream word width
    localparam int ROW_W        = 9;    // header bits [8:0] carry the row index

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_PULSE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Data words needed to cover every bit line of one row.
    function automatic int calc_nw(input int bl_width, input int word_w);
        return (bl_width + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/mb_wl_decoder.sv
// ---------------------------------------------------------------------------
// mb_wl_decoder
// Registered row-index to one-hot word-line decoder. While i_en is high the
// word line selected by i_row is driven on the following cycle; otherwise
// all word lines are low. Registering the output keeps wl glitch-free.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   i_en   in   drive the selected word line next cycle
//   i_row  in   row index (ROW_W bits)
//   o_wl   out  one-hot or all-zero word-line drive (WL_WIDTH bits)
// ---------------------------------------------------------------------------
module mb_wl_decoder
    import mb_config_pkg::*;
#(
    parameter int WL_WIDTH = DEF_WL_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic [ROW_W-1:0]    i_row,
    output logic [WL_WIDTH-1:0] o_wl
);

    logic [WL_WIDTH-1:0] r_wl;
    logic [WL_WIDTH-1:0] w_onehot;

    always_comb begin
        w_onehot = '0;
        for (int b = 0; b < WL_WIDTH; b++) begin
            w_onehot[b] = (i_row == ROW_W'(b));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wl <= '0;
        end else begin
            r_wl <= i_en ? w_onehot : '0;
        end
    end

    assign o_wl = r_wl;

endmodule

// File: rtl/mb_config_loader.sv
// ---------------------------------------------------------------------------
// mb_config_loader
// Streams configuration frames into the fabric. Each frame is one header
// word (row index in bits [8:0]) followed by NW data words that fill a
// BL_WIDTH-bit shadow register; the row's word line is then pulsed for
// PULSE_CYCLES cycles, followed by a one-cycle gap. After WL_WIDTH frames
// the session ends in DONE; an out-of-range row ends it in ERR.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   begin a session (honoured only in IDLE)
//   s_data     in   bitstream word (WORD_W bits)
//   s_valid    in   s_data valid
//   s_ready    out  loader accepts s_data this cycle
//   bl         out  bit-line drive (BL_WIDTH bits)
//   wl         out  word-line drive, one-hot or zero (WL_WIDTH bits)
//   busy       out  session in progress
//   cfg_done   out  sticky: session completed
//   cfg_error  out  sticky: illegal row index received
// ---------------------------------------------------------------------------
module mb_config_loader
    import mb_config_pkg::*;
#(
    parameter int BL_WIDTH     = DEF_BL_WIDTH,
    parameter int WL_WIDTH     = DEF_WL_WIDTH,
    parameter int WORD_W       = DEF_WORD_W,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int NW      = calc_nw(BL_WIDTH, WORD_W);
    localparam int FRAME_W = $clog2(WL_WIDTH + 1);
    localparam int WCNT_W  = $clog2(NW + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [7:0]          r_pulse_cnt;
    logic [ROW_W-1:0]    r_row;
    logic [BL_WIDTH-1:0] r_bl;
    logic [BL_WIDTH-1:0] w_bl_wr;
    logic                r_cfg_done;
    logic                r_cfg_error;
    logic                w_xfer;
    logic                w_row_ok;
    logic                w_last_word;
    logic                w_pulse_end;
    logic                w_last_frame;
    logic                w_enter_hdr;
    logic [ROW_W-1:0]    w_hdr_row;

    assign w_hdr_row    = s_data[ROW_W-1:0];
    assign w_row_ok     = 32'(w_hdr_row) < 32'(WL_WIDTH);
    assign w_xfer       = s_valid & s_ready;
    assign w_last_word  = (r_word_cnt == WCNT_W'(NW - 1));
    assign w_pulse_end  = (r_pulse_cnt == 8'(PULSE_CYCLES - 1));
    assign w_last_frame = (r_frame_cnt == FRAME_W'(WL_WIDTH - 1));
    assign w_enter_hdr  = (w_state_next == ST_HDR) && (r_state != ST_HDR);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignment so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        s_ready      = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = ST_HDR;
            end
            ST_HDR: begin
                s_ready = 1'b1;
                if (s_valid) w_state_next = w_row_ok ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                s_ready = 1'b1;
                if (s_valid && w_last_word) w_state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (w_pulse_end) w_state_next = ST_GAP;
            end
            ST_GAP: begin
                w_state_next = w_last_frame ? ST_DONE : ST_HDR;
            end
            ST_DONE, ST_ERR: begin
                busy = 1'b0;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ BL slice write
    // Word k lands on bl[k*WORD_W +: WORD_W]; bits beyond BL_WIDTH-1 simply
    // have no destination.
    always_comb begin
        w_bl_wr = r_bl;
        for (int b = 0; b < BL_WIDTH; b++) begin
            if (r_word_cnt == WCNT_W'(b / WORD_W)) begin
                w_bl_wr[b] = s_data[b % WORD_W];
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide shadow register is a plain flop bank, not a RAM,
            // so it is cleared here like any other register.
            r_bl        <= '0;
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
            r_pulse_cnt <= '0;
            r_row       <= '0;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            // Shadow register: cleared per frame and in the terminal states.
            if (w_enter_hdr) begin
                r_bl       <= '0;
                r_word_cnt <= '0;
            end else if (r_state == ST_DATA && w_xfer) begin
                r_bl       <= w_bl_wr;
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
            end else if (w_state_next == ST_DONE || w_state_next == ST_ERR) begin
                r_bl <= '0;
            end

            if (r_state == ST_HDR && w_xfer && w_row_ok) begin
                r_row <= w_hdr_row;
            end

            if (r_state == ST_PULSE && !w_pulse_end) begin
                r_pulse_cnt <= r_pulse_cnt + 8'd1;
            end else begin
                r_pulse_cnt <= '0;
            end

            if (r_state == ST_GAP) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end

            r_cfg_done  <= r_cfg_done  | (w_state_next == ST_DONE);
            r_cfg_error <= r_cfg_error | (w_state_next == ST_ERR);
        end
    end

    // Word line follows the PULSE state one-for-one because the enable is
    // taken from the next state and the decoder registers it.
    mb_wl_decoder #(
        .WL_WIDTH (WL_WIDTH)
    ) u_wl_decoder (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_state_next == ST_PULSE),
        .i_row (r_row),
        .o_wl  (wl)
    );

    assign bl        = r_bl;
    assign cfg_done  = r_cfg_done;
    assign cfg_error = r_cfg_error;

endmodule
